fp_round_unit: RTL

- Rounding stage directly downstream of the FP multiply unit.
- Consumes the multiplier's unrounded float_t result, its guard/round/sticky bits and its exception flags.
- Applies the RISC-V rounding mode, renormalises on significand carry, and resolves overflow/underflow/invalid into the final IEEE-754 single result and flags.
- Multi-cycle FSM with valid/ready handshake and a clock enable, feeding the FP writeback path.

---
 rtl/fp_round_unit_pkg.sv | 58 +++++
 rtl/fp_round_decide.sv | 29 ++
 rtl/fp_round_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fp_round_unit_pkg.sv
// Shared types and constants for the single-precision rounding stage.
// Also used by fp_round_decide so the add/div rounding paths can reuse it.
package fp_round_unit_pkg;

   localparam int unsigned FLOAT_W = 32;
   localparam int unsigned EXP_W   = 8;
   localparam int unsigned MANT_W  = 23;
   localparam int unsigned SIG_W   = MANT_W + 1;
   localparam int unsigned SUM_W   = SIG_W + 1;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exponent;
      logic [MANT_W-1:0] mantissa;
   } float_t;

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100
   } rnd_mode_e;

   typedef enum logic {
      FREE = 1'b0,
      BUSY = 1'b1
   } fu_state_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ROUND     = 2'd1,
      NORMALIZE = 2'd2,
      DONE      = 2'd3
   } round_state_e;

   localparam logic [FLOAT_W-1:0] CANONICAL_NAN  = 32'h7FC00000;
   localparam logic [FLOAT_W-2:0] MAX_FINITE_MAG = 31'h7F7FFFFF;
   localparam logic [FLOAT_W-2:0] INF_MAG        = 31'h7F800000;

   function automatic logic rm_legal(input logic [2:0] rm);
      return rm <= 3'(RMM);
   endfunction

   // Saturated result when the magnitude exceeds the format, sign preserved.
   function automatic float_t overflow_result(input logic sign, input logic [2:0] rm);
      logic [FLOAT_W-2:0] mag;
      mag = INF_MAG;
      case (rnd_mode_e'(rm))
         RTZ:     mag = MAX_FINITE_MAG;
         RDN:     mag = sign ? INF_MAG : MAX_FINITE_MAG;
         RUP:     mag = sign ? MAX_FINITE_MAG : INF_MAG;
         default: mag = INF_MAG;
      endcase
      return float_t'({sign, mag});
   endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Rounding decision from sign, LSB and guard/round/sticky under a RISC-V
// rounding mode; purely combinational.
module fp_round_decide
   import fp_round_unit_pkg::*;
(
   input  logic       sign,
   input  logic       l,
   input  logic       g,
   input  logic       r,
   input  logic       s,
   input  logic [2:0] rm,
   output logic       increment,
   output logic       inexact
);

   always_comb begin
      inexact   = g | r | s;
      increment = 1'b0;
      case (rnd_mode_e'(rm))
         RNE:     increment = g & (r | s | l);
         RTZ:     increment = 1'b0;
         RDN:     increment = sign & inexact;
         RUP:     increment = ~sign & inexact;
         RMM:     increment = g;
         default: increment = 1'b0;
      endcase
   end

endmodule

// File: rtl/fp_round_unit.sv
// Rounding stage after the FP multiplier: rounds, renormalises and resolves
// exceptions into the final single-precision result over three enabled cycles.
module fp_round_unit
   import fp_round_unit_pkg::*;
#(
   parameter int unsigned RESULT_W = FLOAT_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clk_en_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [RESULT_W-1:0] to_round_unit_i,
   input  logic [2:0]          grs_i,
   input  logic [2:0]          rounding_mode_i,
   input  logic                overflow_i,
   input  logic                underflow_i,
   input  logic                invalid_op_i,
   output logic [RESULT_W-1:0] result_o,
   output logic                valid_o,
   output fu_state_e           fu_state_o,
   output logic                overflow_o,
   output logic                underflow_o,
   output logic                inexact_o,
   output logic                invalid_op_o
);

   round_state_e     state, state_n;
   float_t           op;
   logic [2:0]       grs_q, rm_q;
   logic             ovf_q, unf_q, inv_q;
   logic [SUM_W-1:0] sum_q, sum_c;
   logic             inexact_q, inc_c, inexact_c;
   float_t           res_c;
   logic             ovf_c, unf_c, inx_c, inv_c;
   logic [EXP_W-1:0] exp_c;
   logic             accept_c;

   assign ready_o  = (state == IDLE) || (state == DONE);
   assign accept_c = valid_i & ready_o & clk_en_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)         state <= IDLE;
      else if (clk_en_i) state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (valid_i) state_n = ROUND;
         ROUND:     state_n = NORMALIZE;
         NORMALIZE: state_n = DONE;
         DONE:      state_n = valid_i ? ROUND : IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op    <= '0;
         grs_q <= '0;
         rm_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         inv_q <= 1'b0;
      end else if (accept_c) begin
         op    <= float_t'(to_round_unit_i);
         grs_q <= grs_i;
         rm_q  <= rounding_mode_i;
         ovf_q <= overflow_i;
         unf_q <= underflow_i;
         inv_q <= invalid_op_i;
      end
   end

   fp_round_decide u_decide (
      .sign      (op.sign),
      .l         (op.mantissa[0]),
      .g         (grs_q[2]),
      .r         (grs_q[1]),
      .s         (grs_q[0]),
      .rm        (rm_q),
      .increment (inc_c),
      .inexact   (inexact_c)
   );

   // 25-bit sum keeps the carry out of the hidden bit for renormalisation.
   assign sum_c = {1'b0, 1'b1, op.mantissa} + SUM_W'(inc_c);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sum_q     <= '0;
         inexact_q <= 1'b0;
      end else if (clk_en_i && (state == ROUND)) begin
         sum_q     <= sum_c;
         inexact_q <= inexact_c;
      end
   end

   // Exception priority: invalid/illegal rm, Inf/NaN input, overflow, underflow, rounding.
   always_comb begin
      res_c = op;
      ovf_c = 1'b0;
      unf_c = 1'b0;
      inx_c = 1'b0;
      inv_c = 1'b0;
      exp_c = op.exponent + EXP_W'(sum_q[SUM_W-1]);
      if (inv_q || !rm_legal(rm_q)) begin
         res_c = float_t'(CANONICAL_NAN);
         inv_c = 1'b1;
      end else if (op.exponent == '1) begin
         res_c = op;
      end else if (ovf_q) begin
         res_c = overflow_result(op.sign, rm_q);
         ovf_c = 1'b1;
         inx_c = 1'b1;
      end else if (unf_q) begin
         res_c      = '0;
         res_c.sign = op.sign;
         unf_c      = 1'b1;
         inx_c      = 1'b1;
      end else if (exp_c == '1) begin
         res_c = overflow_result(op.sign, rm_q);
         ovf_c = 1'b1;
         inx_c = 1'b1;
      end else begin
         res_c.exponent = exp_c;
         res_c.mantissa = sum_q[SUM_W-1] ? sum_q[MANT_W:1] : sum_q[MANT_W-1:0];
         inx_c          = inexact_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_o     <= '0;
         valid_o      <= 1'b0;
         fu_state_o   <= FREE;
         overflow_o   <= 1'b0;
         underflow_o  <= 1'b0;
         inexact_o    <= 1'b0;
         invalid_op_o <= 1'b0;
      end else if (clk_en_i) begin
         valid_o    <= (state == NORMALIZE);
         fu_state_o <= ((state_n == IDLE) || (state_n == DONE)) ? FREE : BUSY;
         if (state == NORMALIZE) begin
            result_o     <= RESULT_W'(res_c);
            overflow_o   <= ovf_c;
            underflow_o  <= unf_c;
            inexact_o    <= inx_c;
            invalid_op_o <= inv_c;
         end
      end
   end

endmodule
